// File: rtl/aftab_irq_pending_bank_pkg.sv
// aftab_irq_pending_bank_pkg: shared constants and encodings for the interrupt pending bank
package aftab_irq_pending_bank_pkg;
  localparam int AFTAB_MAX_IRQ = 32;
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;
  typedef enum logic {LEVEL = 1'b0, EDGE = 1'b1} mode_t;
endpackage

// File: rtl/aftab_irq_pending_bank_channel.sv
// aftab_irq_channel: one interrupt line with synchroniser, edge detect and pending flop
module aftab_irq_channel
  import aftab_irq_pending_bank_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  input  logic edge_sel,
  input  logic clr,
  output logic pending
);
  logic s;
  logic prev;
  if (SYNC_STAGES == 0) begin : g_direct
    assign s = irq_in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync;
    // shift the raw line through the synchroniser chain
    always_ff @(posedge clk)
      sync <= rst ? '0 : (sync << 1) | SYNC_STAGES'(irq_in);
    assign s = sync[SYNC_STAGES-1];
  end
  // edge mode: a new edge beats a same-cycle clear; level mode: follow the line
  always_ff @(posedge clk) begin
    prev    <= rst ? 1'b0 : s;
    pending <= rst ? 1'b0 :
               (mode_t'(edge_sel) == EDGE) ? ((pending & ~clr) | (s & ~prev)) : s;
  end
endmodule

// File: rtl/aftab_irq_pending_bank.sv
// aftab_irq_pending_bank: per-channel pending capture, mask, lowest-index priority and req/ack FSM
module aftab_irq_pending_bank
  import aftab_irq_pending_bank_pkg::*;
#(
  parameter int NUM_IRQ     = 16,
  parameter int ID_W        = $clog2(NUM_IRQ),
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] edge_sel,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               clr_we,
  input  logic [NUM_IRQ-1:0] clr_vec,
  input  logic               global_en,
  input  logic               irq_ack,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] mask_out,
  output logic [NUM_IRQ-1:0] pending_out
);
  state_t              state, state_nxt;
  logic [ID_W-1:0]     id_q, id_nxt, winner;
  logic [NUM_IRQ-1:0]  mask, pending, eligible, clr;
  logic                any;
  assign clr      = ({NUM_IRQ{clr_we}} & clr_vec) |
                    ((state == REQ && irq_ack) ? (NUM_IRQ'(1) << id_q) : '0);
  assign eligible = pending & mask;
  assign any      = (|eligible) & global_en;
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
    aftab_irq_channel #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .irq_in   (irq_in[i]),
      .edge_sel (edge_sel[i]),
      .clr      (clr[i]),
      .pending  (pending[i])
    );
  end
  // software mask register
  always_ff @(posedge clk)
    mask <= rst ? '0 : mask_we ? mask_wdata : mask;
  // lowest eligible index wins
  always_comb begin
    winner = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--)
      if (eligible[k]) winner = ID_W'(k);
  end
  // state and latched request id
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nxt;
    id_q  <= rst ? '0 : id_nxt;
  end
  // latch a winner from IDLE; leave REQ on ack or when the request loses eligibility
  always_comb begin
    state_nxt = (state == IDLE) ? (any ? REQ : IDLE) :
                (irq_ack || !eligible[id_q] || !global_en) ? IDLE : REQ;
    id_nxt    = (state == IDLE && any) ? winner : id_q;
  end
  // outputs are pure functions of registered state
  always_comb begin
    irq_req     = (state == REQ);
    irq_id      = id_q;
    mask_out    = mask;
    pending_out = pending;
  end
endmodule
